// File: rtl/fdtd_field_mem_slv_if.sv
// AXI4 bus bundle carrying the AW/W/B/AR/R fields the FDTD field memory uses.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [1:0]                aw_burst;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [1:0]                ar_burst;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_burst, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_burst, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_burst, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_burst, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/fdtd_field_mem_slv.sv
// AXI4 field-data memory for the FDTD engine: independent write and read burst
// engines over a byte-strobed word array; errors are reported as SLVERR.
module fdtd_field_mem_slv #(
  parameter int unsigned                AXI_ADDR_WIDTH = 32,
  parameter int unsigned                AXI_DATA_WIDTH = 32,
  parameter int unsigned                AXI_ID_WIDTH   = 4,
  parameter int unsigned                AXI_USER_WIDTH = 1,
  parameter int unsigned                MEM_DEPTH      = 256,
  parameter logic [AXI_ADDR_WIDTH-1:0]  BASE_ADDR      = 'h0010_0000
) (
  input  logic       ACLK,
  input  logic       ARESETn,
  AXI_BUS.Slave      slv,
  output logic       busy_o,
  output logic [3:0] dbg_state
);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_BYTES = AXI_ADDR_WIDTH'(STRB_W);
  localparam logic [AXI_ADDR_WIDTH-1:0] MEM_BYTES  = AXI_ADDR_WIDTH'(MEM_DEPTH * STRB_W);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} r_state_e;

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> LSB);
  endfunction

  // WRAP and the reserved encoding are both refused; only FIXED and INCR move data.
  function automatic logic burst_ok(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

  // Valid/ready: a transfer happens on every rising edge where both are high;
  // this slave raises ready only in the state that accepts the channel and
  // holds every valid output and its payload unchanged until accepted.

  // ---------------- write engine ----------------
  w_state_e                  w_state;
  logic                      aw_ready_q, w_ready_q, b_valid_q;
  logic [1:0]                b_resp_q;
  logic [AXI_ID_WIDTH-1:0]   b_id_q, w_id;
  logic [AXI_ADDR_WIDTH-1:0] w_addr;
  logic [7:0]                w_len, w_cnt;
  logic [1:0]                w_burst;
  logic                      w_err;

  logic w_hs, w_beat_ok, w_is_last, w_next_err;
  logic [IDX_W-1:0] w_idx;

  assign w_hs       = slv.w_valid && w_ready_q;
  assign w_beat_ok  = in_range(w_addr) && burst_ok(w_burst);
  assign w_is_last  = (w_cnt == w_len);
  assign w_idx      = word_idx(w_addr);
  assign w_next_err = w_err || !w_beat_ok || (slv.w_last != w_is_last);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state    <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      b_id_q     <= '0;
      w_id       <= '0;
      w_addr     <= '0;
      w_len      <= '0;
      w_cnt      <= '0;
      w_burst    <= BURST_INCR;
      w_err      <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          aw_ready_q <= 1'b1;
          if (slv.aw_valid && aw_ready_q) begin
            w_id       <= slv.aw_id;
            w_addr     <= slv.aw_addr;
            w_len      <= slv.aw_len;
            w_burst    <= slv.aw_burst;
            w_cnt      <= '0;
            w_err      <= !burst_ok(slv.aw_burst);
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b1;
            w_state    <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_err <= w_next_err;
            if (w_is_last) begin
              w_ready_q <= 1'b0;
              b_valid_q <= 1'b1;
              b_resp_q  <= w_next_err ? RESP_SLVERR : RESP_OKAY;
              b_id_q    <= w_id;
              w_state   <= W_RESP;
            end else begin
              w_cnt <= w_cnt + 8'd1;
              if (w_burst == BURST_INCR) w_addr <= w_addr + BEAT_BYTES;
            end
          end
        end
        W_RESP: begin
          if (slv.b_ready) begin
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
            w_state    <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Field memory is never reset so solver state survives an interface reset.
  always_ff @(posedge ACLK) begin
    if (w_hs && w_beat_ok) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (slv.w_strb[b]) mem[w_idx][8*b +: 8] <= slv.w_data[8*b +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  r_state_e                  r_state;
  logic                      ar_ready_q, r_valid_q, r_last_q;
  logic [1:0]                r_resp_q;
  logic [AXI_DATA_WIDTH-1:0] r_data_q;
  logic [AXI_ID_WIDTH-1:0]   r_id_q, r_id_cap;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [7:0]                r_len, r_cnt;
  logic [1:0]                r_burst;

  logic r_beat_ok;
  logic [IDX_W-1:0] r_idx;

  assign r_beat_ok = in_range(r_addr) && burst_ok(r_burst);
  assign r_idx     = word_idx(r_addr);

  // The fetch samples mem with non-blocking semantics, so a write landing on
  // the same edge is not yet visible: the beat carries the old word.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= R_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_resp_q   <= RESP_OKAY;
      r_data_q   <= '0;
      r_id_q     <= '0;
      r_id_cap   <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_burst    <= BURST_INCR;
    end else begin
      case (r_state)
        R_IDLE: begin
          ar_ready_q <= 1'b1;
          if (slv.ar_valid && ar_ready_q) begin
            r_id_cap   <= slv.ar_id;
            r_addr     <= slv.ar_addr;
            r_len      <= slv.ar_len;
            r_burst    <= slv.ar_burst;
            r_cnt      <= '0;
            ar_ready_q <= 1'b0;
            r_state    <= R_FETCH;
          end
        end
        R_FETCH: begin
          r_data_q  <= r_beat_ok ? mem[r_idx] : '0;
          r_resp_q  <= r_beat_ok ? RESP_OKAY : RESP_SLVERR;
          r_last_q  <= (r_cnt == r_len);
          r_id_q    <= r_id_cap;
          r_valid_q <= 1'b1;
          r_state   <= R_DATA;
        end
        R_DATA: begin
          if (slv.r_ready) begin
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            if (r_cnt == r_len) begin
              ar_ready_q <= 1'b1;
              r_state    <= R_IDLE;
            end else begin
              r_cnt   <= r_cnt + 8'd1;
              if (r_burst == BURST_INCR) r_addr <= r_addr + BEAT_BYTES;
              r_state <= R_FETCH;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- outputs ----------------
  assign slv.aw_ready = aw_ready_q;
  assign slv.w_ready  = w_ready_q;
  assign slv.b_valid  = b_valid_q;
  assign slv.b_resp   = b_resp_q;
  assign slv.b_id     = b_id_q;
  assign slv.b_user   = '0;
  assign slv.ar_ready = ar_ready_q;
  assign slv.r_valid  = r_valid_q;
  assign slv.r_data   = r_data_q;
  assign slv.r_resp   = r_resp_q;
  assign slv.r_last   = r_last_q;
  assign slv.r_id     = r_id_q;
  assign slv.r_user   = '0;

  assign busy_o    = (w_state != W_IDLE) || (r_state != R_IDLE);
  assign dbg_state = {w_state, r_state};
endmodule

// File: doc/fdtd_field_mem_slv.md
FDTD_FIELD_MEM_SLV -- requirements
Module: fdtd_field_mem_slv

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, giving the number of AXI_DATA_WIDTH-bit field-data words held.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0010_0000, giving the byte address of word 0.
REQ-003 SHALL have port ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port ARESETn, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 SHALL have port slv, AXI_BUS.Slave: the AXI4 responder serving the FDTD master's Hy/Ez burst traffic.
- Uses channels AW, W, B, AR and R.
- Uses fields id, addr, len, burst, data, strb, last, resp, valid and ready.
- Ties all other response fields (user etc.) to 0.
REQ-006 SHALL have port busy_o, output, 1 bit: high while either the read or the write engine is not idle.

Function
REQ-007 SHALL run independent write and read engines, so that reads and writes proceed concurrently.
REQ-008 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP.
- W_IDLE -> W_DATA on aw_valid&&aw_ready.
- W_DATA -> W_RESP on the w handshake with the beat counter equal to the captured len.
- W_RESP -> W_IDLE on b_valid&&b_ready.
REQ-009 aw_ready SHALL be 1 only in W_IDLE.
- On the AW handshake, capture id, addr, len and burst.
- Clear the 8-bit beat counter.
REQ-010 w_ready SHALL be 1 only in W_DATA.
- Each W handshake writes the bytes selected by w_strb to word (addr-BASE_ADDR)>>2.
- The write lands in the same cycle.
REQ-011 Burst addressing SHALL be set by the captured burst type.
- INCR: the address advances by AXI_DATA_WIDTH/8 per beat.
- FIXED: the address is held for all beats.
- WRAP: all beats are accepted, no writes occur, and the response is SLVERR (2'b10).
REQ-012 A beat SHALL be out of range if its address < BASE_ADDR or its word index >= MEM_DEPTH.
- The beat is dropped.
- A sticky error flag is set, so the burst's single B response is SLVERR.
- Otherwise the B response is OKAY (2'b00).
REQ-013 w_last SHALL be ignored for termination; termination follows len.
- w_last low on the final beat, or high on an earlier beat, sets the sticky error (SLVERR).
REQ-014 b_valid SHALL assert in the cycle after the final W handshake and hold until b_ready.
- b_id equals the captured aw id.
REQ-015 Read FSM SHALL have states R_IDLE, R_FETCH and R_DATA.
- ar_ready is 1 only in R_IDLE.
- On the AR handshake, capture id, addr, len and burst, then enter R_FETCH.
REQ-016 R_FETCH SHALL perform a registered array read.
- R_FETCH -> R_DATA with r_valid=1 on the next edge, giving AR-handshake-to-first-r_valid latency of 2 cycles.
REQ-017 In R_DATA, r_valid, r_data, r_resp, r_last and r_id SHALL hold stable until r_ready.
- On the handshake, if this was not the last beat, the engine advances the address and returns to R_FETCH: 2 cycles/beat, with no bubble-free streaming required.
- On the last beat (counter==len), it returns to R_IDLE.
REQ-018 r_last SHALL be 1 exactly on beat len.
- An out-of-range beat or a WRAP burst returns r_data=0 and r_resp=SLVERR for that beat only.
- Other beats return OKAY.
REQ-019 On a same-cycle read fetch and write of the same word, the read SHALL return the pre-write (old) data.
REQ-020 len=0 SHALL be a single-beat burst, and len=255 SHALL complete 256 beats.
- The beat counter does not wrap before completion.

Reset
REQ-021 While ARESETn=0, outputs SHALL be as follows.
- aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last and busy_o are 0.
- b_resp, r_resp, r_data, b_id and r_id are 0.
- Both FSMs are in IDLE.
REQ-022 aw_ready and ar_ready SHALL rise on the first ACLK edge after ARESETn deasserts.
REQ-023 Memory contents SHALL NOT be reset.
REQ-024 Reset asserted mid-burst SHALL abort both engines immediately.
- No B or R response is issued for the aborted transfer.

Verification
REQ-025 Scenario 1, INCR write then read back.
- Stimulus: INCR write at BASE_ADDR+0x10, len=3, data 1,2,3,4, w_strb=4'hF; then INCR read of the same range.
- Required response: b_resp=OKAY and b_id echoed; reads return 1,2,3,4 with r_last only on beat 3; first r_valid 2 cycles after the AR handshake.
REQ-026 Scenario 2, byte-strobe write.
- Stimulus: write 32'hAABBCCDD to word 5 with w_strb=4'b0101 over prior contents 32'h11223344.
- Required response: a read returns 32'h11BB33DD.
REQ-027 Scenario 3, out-of-range burst.
- Stimulus: INCR write of len=1 starting at the last valid word.
- Required response: beat 0 is stored, beat 1 is dropped, b_resp=SLVERR; an equivalent read gives r_resp OKAY then SLVERR with r_data=0.
REQ-028 Scenario 4, concurrency and backpressure.
- Stimulus: concurrent 16-beat read and 16-beat write to disjoint regions, with r_ready and b_ready randomly deasserted.
- Required response: both complete; R outputs stay stable while stalled; busy_o falls only after both finish.
REQ-029 Scenario 5, mid-burst reset.
- Stimulus: ARESETn pulsed low after beat 2 of an 8-beat read, then a fresh 1-beat read.
- Required response: r_valid drops immediately; ar_ready is 1 one edge after release; the new read returns correct data and OKAY.
REQ-030 Scenario 6, WRAP burst.
- Stimulus: WRAP burst write with len=3.
- Required response: 4 beats are accepted, memory is unchanged, and b_resp=SLVERR.
